// File: rtl/ddr3_cmd_pkg.sv
// DDR3 command decoder shared definitions.
// Raw bus patterns, decoded command codes and error codes.
package ddr3_cmd_pkg;

    localparam logic [3:0] CMD_NONE = 4'd0;
    localparam logic [3:0] CMD_MRS  = 4'd1;
    localparam logic [3:0] CMD_REF  = 4'd2;
    localparam logic [3:0] CMD_PRE  = 4'd3;
    localparam logic [3:0] CMD_PREA = 4'd4;
    localparam logic [3:0] CMD_ACT  = 4'd5;
    localparam logic [3:0] CMD_WR   = 4'd6;
    localparam logic [3:0] CMD_RD   = 4'd7;
    localparam logic [3:0] CMD_ZQ   = 4'd8;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_ACT_OPEN   = 3'd1;
    localparam logic [2:0] ERR_ACC_CLOSED = 3'd2;
    localparam logic [2:0] ERR_REF_OPEN   = 3'd3;
    localparam logic [2:0] ERR_MODE_OPEN  = 3'd4;
    localparam logic [2:0] ERR_TRCD       = 3'd5;
    localparam logic [2:0] ERR_TRP        = 3'd6;

    // {csn, rasn, casn, wen}
    localparam logic [3:0] PAT_MRS = 4'b0000;
    localparam logic [3:0] PAT_REF = 4'b0001;
    localparam logic [3:0] PAT_PRE = 4'b0010;
    localparam logic [3:0] PAT_ACT = 4'b0011;
    localparam logic [3:0] PAT_WR  = 4'b0100;
    localparam logic [3:0] PAT_RD  = 4'b0101;
    localparam logic [3:0] PAT_ZQ  = 4'b0110;
    localparam logic [3:0] PAT_NOP = 4'b0111;

    // NOP and any deselect (csn=1) map to CMD_NONE.
    function automatic logic [3:0] cmd_decode(
        input logic [3:0] pat,
        input logic       a10
    );
        logic [3:0] c;
        c = CMD_NONE;
        case (pat)
            PAT_MRS: c = CMD_MRS;
            PAT_REF: c = CMD_REF;
            PAT_PRE: c = a10 ? CMD_PREA : CMD_PRE;
            PAT_ACT: c = CMD_ACT;
            PAT_WR:  c = CMD_WR;
            PAT_RD:  c = CMD_RD;
            PAT_ZQ:  c = CMD_ZQ;
            default: c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ddr3_cmd_decoder_bank_timer.sv
// Per-bank down-counter used for ACT->RD/WR and PRE->ACT spacing.
// Load wins over decrement; counter holds at zero.
module ddr3_bank_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load on bank command, otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ddr3_cmd_decoder.sv
// Memory-side DDR3 command decoder with bank tracking and error flags.
// Optional per-bank tRCD/tRP checks under DDR3_CMD_TIMING_CHECK_EN.
module ddr3_cmd_decoder
    import ddr3_cmd_pkg::*;
#(
    parameter int BANKS  = 8,
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 16,
    parameter int TRCD   = 5,
    parameter int TRP    = 5
) (
    input  logic                     ddr3_ck0,
    input  logic                     ddr3_rstn,
    input  logic                     ddr3_cke,
    input  logic                     ddr3_csn,
    input  logic                     ddr3_rasn,
    input  logic                     ddr3_casn,
    input  logic                     ddr3_wen,
    input  logic [$clog2(BANKS)-1:0] ddr3_ba,
    input  logic [ADDR_W-1:0]        ddr3_a,
    input  logic                     clr_counts,
    output logic                     cmd_valid,
    output logic [3:0]               cmd_code,
    output logic [$clog2(BANKS)-1:0] cmd_bank,
    output logic [ADDR_W-1:0]        cmd_addr,
    output logic [BANKS-1:0]         bank_open,
    output logic                     err_valid,
    output logic [2:0]               err_code,
    output logic [CNT_W-1:0]         act_count,
    output logic [CNT_W-1:0]         rd_count,
    output logic [CNT_W-1:0]         wr_count
);

    localparam int BA_W = $clog2(BANKS);

    logic [3:0]       code;
    logic [2:0]       err_n;
    logic [BANKS-1:0] open_n;
    logic [BANKS-1:0] tmr_busy;
    logic             inc_act;
    logic             inc_rd;
    logic             inc_wr;
    logic             cur_open;

    // Decode the sampled bus; nothing decodes while cke is low.
    always_comb begin
        code = CMD_NONE;
        if (ddr3_cke) begin
            code = cmd_decode(
                {ddr3_csn, ddr3_rasn, ddr3_casn, ddr3_wen},
                ddr3_a[10]);
        end
    end

    assign cur_open = bank_open[ddr3_ba];

`ifdef DDR3_CMD_TIMING_CHECK_EN
    localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    for (genvar n = 0; n < BANKS; n++) begin : g_tmr
        logic          hit;
        logic          ld;
        logic [TW-1:0] val;
        logic          zero;

        assign hit = (ddr3_ba == BA_W'(n));
        assign ld  = (((code == CMD_ACT) || (code == CMD_PRE)) && hit)
                   || (code == CMD_PREA);
        assign val = (code == CMD_ACT) ? TW'(TRCD - 1) : TW'(TRP - 1);

        ddr3_bank_timer #(
            .W(TW)
        ) u_tmr (
            .clk      (ddr3_ck0),
            .rst_n    (ddr3_rstn),
            .load     (ld),
            .load_val (val),
            .dec      (ddr3_cke),
            .zero     (zero)
        );

        assign tmr_busy[n] = ~zero;
    end
`else
    assign tmr_busy = '0;
`endif

    // Next bank state, error classification and counter strobes.
    always_comb begin
        open_n  = bank_open;
        err_n   = ERR_NONE;
        inc_act = 1'b0;
        inc_rd  = 1'b0;
        inc_wr  = 1'b0;
        case (code)
            CMD_ACT: begin
                inc_act = 1'b1;
                open_n[ddr3_ba] = 1'b1;
                if (cur_open) begin
                    err_n = ERR_ACT_OPEN;
                end else if (tmr_busy[ddr3_ba]) begin
                    err_n = ERR_TRP;
                end
            end
            CMD_RD, CMD_WR: begin
                inc_rd = (code == CMD_RD);
                inc_wr = (code == CMD_WR);
                if (ddr3_a[10]) begin
                    open_n[ddr3_ba] = 1'b0;
                end
                if (!cur_open) begin
                    err_n = ERR_ACC_CLOSED;
                end else if (tmr_busy[ddr3_ba]) begin
                    err_n = ERR_TRCD;
                end
            end
            CMD_PRE: begin
                open_n[ddr3_ba] = 1'b0;
            end
            CMD_PREA: begin
                open_n = '0;
            end
            CMD_REF: begin
                if (|bank_open) begin
                    err_n = ERR_REF_OPEN;
                end
            end
            CMD_MRS, CMD_ZQ: begin
                if (|bank_open) begin
                    err_n = ERR_MODE_OPEN;
                end
            end
            default: begin
                open_n = bank_open;
            end
        endcase
    end

    // Register the decoded command, error and bank state together.
    always_ff @(posedge ddr3_ck0) begin
        if (!ddr3_rstn) begin
            cmd_valid <= 1'b0;
            cmd_code  <= CMD_NONE;
            cmd_bank  <= '0;
            cmd_addr  <= '0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            bank_open <= '0;
        end else begin
            cmd_valid <= (code != CMD_NONE);
            cmd_code  <= code;
            cmd_bank  <= (code != CMD_NONE) ? ddr3_ba : '0;
            cmd_addr  <= (code != CMD_NONE) ? ddr3_a : '0;
            err_valid <= (err_n != ERR_NONE);
            err_code  <= err_n;
            bank_open <= open_n;
        end
    end

    // Saturating command counters; clear beats a coincident increment.
    always_ff @(posedge ddr3_ck0) begin
        if (!ddr3_rstn || clr_counts) begin
            act_count <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            if (inc_act && (act_count != '1)) begin
                act_count <= act_count + 1'b1;
            end
            if (inc_rd && (rd_count != '1)) begin
                rd_count <= rd_count + 1'b1;
            end
            if (inc_wr && (wr_count != '1)) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_decoder.sv
// Directed table-driven bench for ddr3_cmd_decoder (CNT_W=4).
// Timing-check expectations follow DDR3_CMD_TIMING_CHECK_EN.
module tb_ddr3_cmd_decoder;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] MRS = 4'b0000;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] ZQ  = 4'b0110;
    localparam logic [3:0] DES = 4'b1010;

    logic        clk = 1'b0;
    logic        rstn, cke, csn, rasn, casn, wen, clr;
    logic [2:0]  ba;
    logic [12:0] a;
    logic        cmd_valid, err_valid;
    logic [3:0]  cmd_code;
    logic [2:0]  cmd_bank, err_code;
    logic [12:0] cmd_addr;
    logic [7:0]  bank_open;
    logic [3:0]  act_count, rd_count, wr_count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rstn, cke, clr;
        logic [3:0]  pat;
        logic [2:0]  ba;
        logic [12:0] a;
        logic        v;
        logic [3:0]  code;
        logic [2:0]  bank;
        logic [12:0] addr;
        logic [7:0]  open;
        logic        ev;
        logic [2:0]  ec;
        logic [3:0]  act, rd, wr;
    } vec_t;

    vec_t vq[$];

    ddr3_cmd_decoder #(
        .BANKS  (8),
        .ADDR_W (13),
        .CNT_W  (4),
        .TRCD   (5),
        .TRP    (5)
    ) dut (
        .ddr3_ck0   (clk),
        .ddr3_rstn  (rstn),
        .ddr3_cke   (cke),
        .ddr3_csn   (csn),
        .ddr3_rasn  (rasn),
        .ddr3_casn  (casn),
        .ddr3_wen   (wen),
        .ddr3_ba    (ba),
        .ddr3_a     (a),
        .clr_counts (clr),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_bank   (cmd_bank),
        .cmd_addr   (cmd_addr),
        .bank_open  (bank_open),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .act_count  (act_count),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic k, input logic c,
                        input logic [3:0] p, input logic [2:0] b,
                        input logic [12:0] ad);
        @(negedge clk);
        rstn = r;
        cke  = k;
        clr  = c;
        {csn, rasn, casn, wen} = p;
        ba = b;
        a  = ad;
        @(posedge clk);
        #1;
    endtask

    task automatic add(
        input logic r, k, c, input logic [3:0] p,
        input logic [2:0] b, input logic [12:0] ad,
        input logic v, input logic [3:0] code,
        input logic [2:0] bank, input logic [12:0] addr,
        input logic [7:0] open, input logic ev,
        input logic [2:0] ec, input logic [3:0] na,
        input logic [3:0] nr, input logic [3:0] nw);
        vec_t t;
        t.rstn = r; t.cke = k; t.clr = c; t.pat = p;
        t.ba = b; t.a = ad; t.v = v; t.code = code;
        t.bank = bank; t.addr = addr; t.open = open;
        t.ev = ev; t.ec = ec; t.act = na; t.rd = nr; t.wr = nw;
        vq.push_back(t);
    endtask

    initial begin
        logic [2:0] exp_e5, exp_e6;
        rstn = 1'b0; cke = 1'b1; clr = 1'b0;
        {csn, rasn, casn, wen} = NOP;
        ba = '0; a = '0;

        add(0,1,0,NOP,0,13'h000, 0,0,0,13'h000,8'h00,0,0,0,0,0);
        add(1,1,0,ACT,2,13'h123, 1,5,2,13'h123,8'h04,0,0,1,0,0);
        add(1,1,0,ACT,1,13'h010, 1,5,1,13'h010,8'h06,0,0,2,0,0);
        for (int i = 0; i < 5; i++)
            add(1,1,0,NOP,0,13'h000, 0,0,0,13'h000,8'h06,0,0,2,0,0);
        add(1,1,0,RD ,1,13'h400, 1,7,1,13'h400,8'h04,0,0,2,1,0);
        add(1,1,0,WR ,3,13'h005, 1,6,3,13'h005,8'h04,1,2,2,1,1);
        add(1,1,0,ACT,0,13'h020, 1,5,0,13'h020,8'h05,0,0,3,1,1);
        add(1,1,0,ACT,0,13'h021, 1,5,0,13'h021,8'h05,1,1,4,1,1);
        add(1,1,0,ACT,5,13'h055, 1,5,5,13'h055,8'h25,0,0,5,1,1);
        add(1,1,0,REF,0,13'h000, 1,2,0,13'h000,8'h25,1,3,5,1,1);
        add(1,1,0,PRE,0,13'h400, 1,4,0,13'h400,8'h00,0,0,5,1,1);
        add(1,1,0,REF,0,13'h000, 1,2,0,13'h000,8'h00,0,0,5,1,1);
        add(1,1,0,MRS,0,13'h00a, 1,1,0,13'h00a,8'h00,0,0,5,1,1);
        add(1,1,0,ZQ ,0,13'h400, 1,8,0,13'h400,8'h00,0,0,5,1,1);
        add(1,1,0,NOP,0,13'h000, 0,0,0,13'h000,8'h00,0,0,5,1,1);
        add(1,1,0,ACT,6,13'h066, 1,5,6,13'h066,8'h40,0,0,6,1,1);
        add(1,0,0,PRE,6,13'h000, 0,0,0,13'h000,8'h40,0,0,6,1,1);
        add(1,1,0,DES,6,13'h000, 0,0,0,13'h000,8'h40,0,0,6,1,1);
        add(1,1,0,PRE,6,13'h000, 1,3,6,13'h000,8'h00,0,0,6,1,1);
        add(1,1,0,PRE,6,13'h000, 1,3,6,13'h000,8'h00,0,0,6,1,1);
        add(1,1,1,RD ,6,13'h000, 1,7,6,13'h000,8'h00,1,2,0,0,0);

        foreach (vq[i]) begin
            vec_t t;
            t = vq[i];
            step(t.rstn, t.cke, t.clr, t.pat, t.ba, t.a);
            chk($sformatf("v%0d valid", i), cmd_valid, t.v);
            chk($sformatf("v%0d open", i), bank_open, t.open);
            chk($sformatf("v%0d err_v", i), err_valid, t.ev);
            chk($sformatf("v%0d act", i), act_count, t.act);
            chk($sformatf("v%0d rd", i), rd_count, t.rd);
            chk($sformatf("v%0d wr", i), wr_count, t.wr);
            if (t.v || !t.rstn) begin
                chk($sformatf("v%0d code", i), cmd_code, t.code);
                chk($sformatf("v%0d bank", i), cmd_bank, t.bank);
                chk($sformatf("v%0d addr", i), cmd_addr, t.addr);
            end
            if (t.ev || !t.rstn)
                chk($sformatf("v%0d err_c", i), err_code, t.ec);
        end

        for (int i = 0; i < 17; i++) begin
            step(1,1,0,RD,0,13'h000);
            if (i == 14) chk("sat rd15", rd_count, 4'd15);
        end
        chk("sat rd", rd_count, 4'd15);
        chk("sat err", err_code, 3'd2);

        step(1,1,0,ACT,2,13'h002);
        chk("mid act", act_count, 4'd1);
        chk("mid open", bank_open, 8'h04);
        step(0,1,0,ACT,3,13'h003);
        chk("rst valid", cmd_valid, 1'b0);
        chk("rst code", cmd_code, 4'd0);
        chk("rst open", bank_open, 8'h00);
        chk("rst act", act_count, 4'd0);
        chk("rst rd", rd_count, 4'd0);
        chk("rst err", {err_valid, err_code}, 4'd0);

`ifdef DDR3_CMD_TIMING_CHECK_EN
        exp_e5 = 3'd5;
        exp_e6 = 3'd6;
`else
        exp_e5 = 3'd0;
        exp_e6 = 3'd0;
`endif
        step(1,1,0,ACT,4,13'h044);
        step(1,1,0,NOP,0,13'h000);
        step(1,1,0,RD ,4,13'h004);
        chk("trcd code", cmd_code, 4'd7);
        chk("trcd err_v", err_valid, exp_e5 != 3'd0);
        chk("trcd err_c", err_code, exp_e5);
        step(1,1,0,PRE,4,13'h000);
        chk("trp pre open", bank_open, 8'h00);
        step(1,1,0,ACT,4,13'h044);
        chk("trp err_v", err_valid, exp_e6 != 3'd0);
        chk("trp err_c", err_code, exp_e6);
        chk("trp open", bank_open, 8'h10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
